// File: rtl/sram_arbiter.sv
// Two-to-one arbiter sharing one sram-like memory port between the instruction and data requesters.
// Optional feature: define SRAM_ARB_RR_EN for round-robin grant on contention (default: fixed data priority).
module sram_arbiter (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        bus_req,
  output logic        bus_wr,
  output logic [1:0]  bus_size,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_addr_ok,
  input  logic        bus_data_ok,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  localparam logic OWNER_INST = 1'b0;
  localparam logic OWNER_DATA = 1'b1;

  state_t state, state_nxt;
  logic   owner;
  logic   last_grant;
  req_t   req_buf;

  req_t   inst_fields;
  req_t   data_fields;
  logic   any_req;
  logic   grant;
  logic   accept;

  assign inst_fields = '{wr: inst_wr, size: inst_size, wstrb: inst_wstrb,
                         addr: inst_addr, wdata: inst_wdata};
  assign data_fields = '{wr: data_wr, size: data_size, wstrb: data_wstrb,
                         addr: data_addr, wdata: data_wdata};

  assign any_req = inst_req | data_req;
  assign accept  = (state == IDLE) && any_req && !reset;

  // With no request pending the grant parks on the previous winner; it is only
  // consumed when some requester is asserting.
  always_comb begin
    if (inst_req && data_req) begin
`ifdef SRAM_ARB_RR_EN
      grant = ~last_grant;
`else
      grant = OWNER_DATA;
`endif
    end else if (data_req) begin
      grant = OWNER_DATA;
    end else if (inst_req) begin
      grant = OWNER_INST;
    end else begin
      grant = last_grant;
    end
  end

  // NOTE: every signal written in a combinational block gets a default first,
  // so no path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req)     state_nxt = REQ;
      REQ:     if (bus_addr_ok) state_nxt = WAIT;
      WAIT:    if (bus_data_ok) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= OWNER_INST;
      last_grant <= OWNER_INST;
      req_buf    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner      <= grant;
        last_grant <= grant;
        req_buf    <= (grant == OWNER_DATA) ? data_fields : inst_fields;
      end
    end
  end

  // Outputs are forced quiet while reset is held so nothing leaks out of a
  // half-finished transaction during the reset cycle itself.
  always_comb begin
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    inst_rdata   = '0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = '0;
    bus_req      = 1'b0;
    bus_wr       = 1'b0;
    bus_size     = '0;
    bus_wstrb    = '0;
    bus_addr     = '0;
    bus_wdata    = '0;
    if (!reset) begin
      case (state)
        IDLE: begin
          inst_addr_ok = any_req && (grant == OWNER_INST);
          data_addr_ok = any_req && (grant == OWNER_DATA);
        end
        REQ: begin
          bus_req   = 1'b1;
          bus_wr    = req_buf.wr;
          bus_size  = req_buf.size;
          bus_wstrb = req_buf.wstrb;
          bus_addr  = req_buf.addr;
          bus_wdata = req_buf.wdata;
        end
        WAIT: begin
          if (bus_data_ok) begin
            if (owner == OWNER_DATA) begin
              data_data_ok = 1'b1;
              data_rdata   = bus_rdata;
            end else begin
              inst_data_ok = 1'b1;
              inst_rdata   = bus_rdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed vector table, reset/protocol corner
// sequences and randomized transactions checked against a transaction-level model.
module tb_sram_arbiter;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        bus_req, bus_wr;
  logic [1:0]  bus_size;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_addr_ok, bus_data_ok;
  logic [31:0] bus_rdata;

  int   n_checks = 0;
  int   n_errors = 0;
  logic model_last;

  typedef struct {
    logic        ireq, dreq, hold, spur;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] iaddr, daddr, iwdata, dwdata;
    int          aok, dok;
    logic [31:0] rdata;
    logic        exp_fixed, exp_rr;
  } vec_t;

  vec_t vecs [8];

  sram_arbiter dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
    .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic check_quiet(input string name);
    check_bit(name, |{inst_addr_ok, inst_data_ok, inst_rdata, data_addr_ok, data_data_ok,
                      data_rdata, bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata}, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic scramble();
    logic [31:0] r;
    r = $urandom;
    inst_wr = r[0]; inst_size = r[2:1]; inst_wstrb = r[6:3];
    data_wr = r[7]; data_size = r[9:8]; data_wstrb = r[13:10];
    inst_addr = $urandom; inst_wdata = $urandom;
    data_addr = $urandom; data_wdata = $urandom;
  endtask

  function automatic vec_t mk(input logic ireq, input logic dreq, input logic hold, input logic spur,
                              input logic wr, input logic [1:0] size, input logic [3:0] wstrb,
                              input logic [31:0] iaddr, input logic [31:0] daddr,
                              input logic [31:0] wdata, input int aok, input int dok,
                              input logic [31:0] rdata, input logic exp_fixed, input logic exp_rr);
    vec_t v;
    v.ireq = ireq; v.dreq = dreq; v.hold = hold; v.spur = spur;
    v.wr = wr; v.size = size; v.wstrb = wstrb;
    v.iaddr = iaddr; v.daddr = daddr; v.dwdata = wdata; v.iwdata = ~wdata;
    v.aok = aok; v.dok = dok; v.rdata = rdata;
    v.exp_fixed = exp_fixed; v.exp_rr = exp_rr;
    return v;
  endfunction

  // Reference grant rule: a lone requester always wins; on contention data wins,
  // or (round-robin build) whoever did not win last time.
  function automatic logic model_grant(input logic ireq, input logic dreq);
    if (ireq && dreq) begin
`ifdef SRAM_ARB_RR_EN
      return ~model_last;
`else
      return OWN_DATA;
`endif
    end
    return dreq ? OWN_DATA : OWN_INST;
  endfunction

  task automatic drive_req(input vec_t v);
    inst_req = v.ireq; data_req = v.dreq;
    inst_wr = v.wr; inst_size = v.size; inst_wstrb = v.wstrb;
    data_wr = v.wr; data_size = v.size; data_wstrb = v.wstrb;
    inst_addr = v.iaddr; inst_wdata = v.iwdata;
    data_addr = v.daddr; data_wdata = v.dwdata;
  endtask

  // One full transaction starting in IDLE; returns positioned in the next IDLE cycle.
  task automatic run_txn(input string tag, input vec_t v, input logic g);
    logic [31:0] e_addr, e_wdata;
    logic        last;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    drive_req(v);
    settle();
    check_bit({tag, "_inst_addr_ok"}, inst_addr_ok, g == OWN_INST);
    check_bit({tag, "_data_addr_ok"}, data_addr_ok, g == OWN_DATA);
    check_bit({tag, "_idle_bus_req"}, bus_req, 1'b0);
    e_addr  = g ? v.daddr  : v.iaddr;
    e_wdata = g ? v.dwdata : v.iwdata;
    model_last = g;
    tick();
    scramble();
    inst_req = v.hold; data_req = v.hold;
    for (int i = 0; i <= v.aok; i++) begin
      bus_addr_ok = (i == v.aok);
      bus_data_ok = v.spur && (i == 0);
      bus_rdata   = $urandom;
      settle();
      check_bit({tag, "_bus_req"}, bus_req, 1'b1);
      check_bit({tag, "_bus_wr"}, bus_wr, v.wr);
      check({tag, "_bus_size"}, 32'(bus_size), 32'(v.size));
      check({tag, "_bus_wstrb"}, 32'(bus_wstrb), 32'(v.wstrb));
      check({tag, "_bus_addr"}, bus_addr, e_addr);
      check({tag, "_bus_wdata"}, bus_wdata, e_wdata);
      check_bit({tag, "_req_addr_ok"}, inst_addr_ok | data_addr_ok, 1'b0);
      check_bit({tag, "_req_data_ok"}, inst_data_ok | data_data_ok, 1'b0);
      tick();
    end
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    for (int i = 0; i <= v.dok; i++) begin
      last        = (i == v.dok);
      bus_data_ok = last;
      bus_rdata   = last ? v.rdata : $urandom;
      settle();
      check_bit({tag, "_wait_bus_req"}, bus_req, 1'b0);
      check_bit({tag, "_wait_addr_ok"}, inst_addr_ok | data_addr_ok, 1'b0);
      check_bit({tag, "_inst_data_ok"}, inst_data_ok, last && g == OWN_INST);
      check_bit({tag, "_data_data_ok"}, data_data_ok, last && g == OWN_DATA);
      if (g == OWN_INST) begin
        check({tag, "_data_rdata"}, data_rdata, 32'h0);
        if (last && !v.wr) check({tag, "_inst_rdata"}, inst_rdata, v.rdata);
      end else begin
        check({tag, "_inst_rdata"}, inst_rdata, 32'h0);
        if (last && !v.wr) check({tag, "_data_rdata"}, data_rdata, v.rdata);
      end
      tick();
    end
    bus_data_ok = 1'b0;
    inst_req = 1'b0; data_req = 1'b0;
  endtask

  initial begin
    vec_t        v;
    logic        g;
    logic [31:0] r;

    //            ireq dreq hold spur wr size  wstrb    iaddr         daddr         wdata         aok dok rdata         fix rr
    vecs[0] = mk(1,   0,   0,   0,   0, 2'd2, 4'h0, 32'h1C000000, 32'h0,        32'h0,        0,  0,  32'h02800C06, 0,  0);
    vecs[1] = mk(1,   1,   1,   0,   0, 2'd2, 4'h0, 32'h1C000004, 32'h1C001000, 32'h0,        0,  0,  32'h11111111, 1,  1);
    vecs[2] = mk(1,   1,   1,   0,   0, 2'd2, 4'h0, 32'h1C000008, 32'h1C001004, 32'h0,        0,  1,  32'h22222222, 1,  0);
    vecs[3] = mk(1,   1,   0,   0,   0, 2'd2, 4'h0, 32'h1C00000C, 32'h1C001008, 32'h0,        1,  0,  32'h33333333, 1,  1);
    vecs[4] = mk(0,   1,   1,   0,   1, 2'd2, 4'hF, 32'h0,        32'h1C008000, 32'hDEADBEEF, 5,  1,  32'h0,        1,  1);
    vecs[5] = mk(1,   0,   0,   1,   0, 2'd2, 4'h0, 32'h1C000010, 32'h0,        32'h0,        2,  2,  32'hA5A55A5A, 0,  0);
    vecs[6] = mk(0,   1,   0,   0,   1, 2'd0, 4'h4, 32'h0,        32'h1C000102, 32'h00AB0000, 1,  0,  32'h0,        1,  1);
    vecs[7] = mk(1,   0,   0,   0,   1, 2'd1, 4'h3, 32'h1C000200, 32'h0,        32'h0000BEEF, 0,  3,  32'h0,        0,  0);

    reset = 1'b1;
    scramble();
    inst_req = 1'b1; data_req = 1'b1;
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'hFFFFFFFF;
    repeat (2) @(posedge clk);
    #4;
    check_quiet("reset_held");
    tick();
    reset = 1'b0; inst_req = 1'b0; data_req = 1'b0;
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
    model_last = OWN_INST;
    settle();
    check_quiet("idle_after_reset");

    // Bus handshakes in IDLE must be ignored.
    tick();
    bus_addr_ok = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'hCAFEF00D;
    settle();
    check_quiet("idle_spurious_bus");
    tick();
    bus_addr_ok = 1'b0; bus_data_ok = 1'b0;

    for (int i = 0; i < 8; i++) begin
`ifdef SRAM_ARB_RR_EN
      g = vecs[i].exp_rr;
`else
      g = vecs[i].exp_fixed;
`endif
      run_txn($sformatf("vec%0d", i), vecs[i], g);
    end

    // Reset while in WAIT, then a late bus_data_ok two cycles after release.
    inst_req = 1'b1; inst_wr = 1'b0; inst_size = 2'd2; inst_addr = 32'h1C000040;
    settle();
    check_bit("rstwait_accept", inst_addr_ok, 1'b1);
    tick();
    inst_req = 1'b0; bus_addr_ok = 1'b1;
    settle();
    check_bit("rstwait_bus_req", bus_req, 1'b1);
    tick();
    bus_addr_ok = 1'b0;
    settle();
    check_bit("rstwait_in_wait", bus_req | inst_data_ok, 1'b0);
    tick();
    reset = 1'b1; bus_data_ok = 1'b1; bus_rdata = 32'h5555AAAA;
    settle();
    check_quiet("rstwait_during_reset");
    tick();
    reset = 1'b0; bus_data_ok = 1'b0;
    settle();
    check_quiet("rstwait_release_0");
    tick();
    settle();
    check_quiet("rstwait_release_1");
    tick();
    bus_data_ok = 1'b1;
    settle();
    check_quiet("rstwait_late_data_ok");
    tick();
    bus_data_ok = 1'b0;
    model_last = OWN_INST;

    for (int n = 0; n < 150; n++) begin
      r = $urandom;
      if (r[2:0] == 3'd0) begin
        inst_req = 1'b0; data_req = 1'b0;
        bus_addr_ok = r[3]; bus_data_ok = r[4]; bus_rdata = $urandom;
        settle();
        check_quiet("rand_idle");
        tick();
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0;
      end else begin
        v.ireq = r[5] | ~r[6];
        v.dreq = r[6];
        v.hold = r[7]; v.spur = r[8]; v.wr = r[9]; v.size = r[11:10]; v.wstrb = r[15:12];
        v.aok = int'(r[17:16]); v.dok = int'(r[19:18]);
        v.iaddr = $urandom; v.daddr = $urandom; v.iwdata = $urandom; v.dwdata = $urandom;
        v.rdata = $urandom;
        v.exp_fixed = 1'b0; v.exp_rr = 1'b0;
        g = model_grant(v.ireq, v.dreq);
        run_txn($sformatf("rand%0d", n), v, g);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-to-one arbiter that shares a single sram-like memory port between the instruction-fetch requester (IFU) and the data-access requester (EXEU issue, MEMU return). It sits between the pipeline and the external memory bridge. It accepts one request at a time into a request buffer, issues it on the shared bus, and routes the response back to its owner. Grant policy is fixed data-priority, or round-robin when configured.

## Interface
- Parameters: none.
- `clk` input 1: sole clock, rising edge.
- `reset` input 1: synchronous, active-high reset.
- `inst_req` input 1: instruction requester has a valid request.
- `inst_wr` input 1: 1 = write, 0 = read.
- `inst_size` input 2: 0 = byte, 1 = half, 2 = word.
- `inst_wstrb` input 4: byte write enables.
- `inst_addr` input 32: request address.
- `inst_wdata` input 32: write data.
- `inst_addr_ok` output 1: request accepted this cycle.
- `inst_data_ok` output 1: response valid this cycle.
- `inst_rdata` output 32: read data, valid with `inst_data_ok`.
- `data_req`, `data_wr`, `data_size`, `data_wstrb`, `data_addr`, `data_wdata`, `data_addr_ok`, `data_data_ok`, `data_rdata`: same directions, widths and meanings as the `inst_*` ports, for the data requester.
- `bus_req` output 1: shared-port request.
- `bus_wr` output 1: shared-port write flag.
- `bus_size` output 2: shared-port transfer size.
- `bus_wstrb` output 4: shared-port byte write enables.
- `bus_addr` output 32: shared-port address.
- `bus_wdata` output 32: shared-port write data.
- `bus_addr_ok` input 1: memory accepted the request.
- `bus_data_ok` input 1: memory response valid.
- `bus_rdata` input 32: read data from memory.

## Operation
- FSM states: IDLE, REQ, WAIT. Registers: `owner` (0 = inst, 1 = data), `last_grant`, and a request buffer holding wr/size/wstrb/addr/wdata.
- IDLE:
  - If any requester is asserting, compute `grant` combinationally.
  - Assert `<grant>_addr_ok` for that cycle only.
  - Latch the granted requester's fields into the buffer; set `owner` = grant and `last_grant` = grant; go to REQ.
  - With no requests, stay in IDLE with all `*_addr_ok` = 0.
- REQ:
  - `bus_req` = 1 and all `bus_*` fields driven from the buffer; they stay stable until accepted.
  - Both `inst_addr_ok` and `data_addr_ok` = 0.
  - On `bus_addr_ok`, go to WAIT.
  - `bus_data_ok` in REQ is a protocol violation and is ignored.
- WAIT:
  - `bus_req` = 0.
  - When `bus_data_ok`: `<owner>_data_ok` = 1 and `<owner>_rdata` = `bus_rdata` (combinational pass-through); go to IDLE.
  - The non-owner's `data_ok` = 0 and its `rdata` = 0.
- Grant (default, fixed priority): data wins whenever `data_req` = 1.
- Only one transaction is outstanding at any time. The next request is accepted no earlier than the cycle after `data_ok`.
- Writes follow the same path. Write `data_ok` is forwarded; `rdata` content is don't-care for writes.

## Timing
- Reset values: state = IDLE, `owner` = 0, `last_grant` = 0 (inst), buffer = 0, `bus_req` = 0, all `bus_*` = 0.
  - All `*_addr_ok` and `*_data_ok` = 0 during and after reset, and all `*_rdata` = 0.
- Latency:
  - Request accept (`addr_ok`) in cycle N.
  - `bus_req` in N+1.
  - If `bus_addr_ok` arrives in N+1, the earliest `data_ok` is N+2.
  - Minimum turnaround is 3 cycles per transaction.
- `bus_req` holds for as many cycles as `bus_addr_ok` stays low. No timeout.
- `bus_addr_ok` without `bus_req` is ignored.
- `bus_data_ok` in IDLE is ignored.
- Reset mid-transaction (REQ or WAIT): the FSM returns to IDLE next cycle and the pending transaction is abandoned. A late `bus_data_ok` arriving in IDLE produces no `*_data_ok`.
- A requester deasserting `req` after being accepted has no effect; the buffered copy is used.

## Configuration
- `SRAM_ARB_RR_EN` defined: when both requesters assert in IDLE, grant goes to the one not equal to `last_grant`. A single requester is always granted.
- `SRAM_ARB_RR_EN` undefined: fixed data priority. `last_grant` is still maintained but unused for the grant decision.

## Test plan
- Single inst read:
  - Stimulus: `inst_req`=1, `inst_addr`=0x1C000000; memory answers `addr_ok` in cycle 1 and `data_ok` in cycle 2 with 0x02800C06.
  - Required: `inst_addr_ok` in cycle 0, `bus_addr`=0x1C000000 in cycle 1, `inst_data_ok`=1 and `inst_rdata`=0x02800C06 in cycle 2, `data_data_ok`=0 throughout.
- Simultaneous requests without the macro:
  - Stimulus: `inst_req` and `data_req` both held at 1 for 3 transactions.
  - Required: all 3 grants go to data; `inst_addr_ok` never asserts.
- Simultaneous requests with `SRAM_ARB_RR_EN`:
  - Stimulus: `inst_req` and `data_req` both held at 1.
  - Required: grants alternate data, inst, data starting from reset.
- Bus stall:
  - Stimulus: data write, addr 0x1C008000, `wstrb`=0xF, `wdata`=0xDEADBEEF; `bus_addr_ok` held low for 5 cycles.
  - Required: `bus_req` and all buffered fields are stable for those 5 cycles; no new `addr_ok` is issued to either requester.
- Reset in WAIT:
  - Stimulus: assert `reset` while in WAIT, then pulse `bus_data_ok` 2 cycles after reset deasserts.
  - Required: all outputs are zero and no `*_data_ok` asserts.
- Spurious `bus_data_ok` in REQ:
  - Stimulus: pulse `bus_data_ok` while in REQ.
  - Required: ignored; the FSM stays in REQ and no `*_data_ok` asserts.
